// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - shared constants and types for the muxn_arb arbiter
package muxn_pkg;

  localparam int MUXN_WIDTH_DEF = 8;
  localparam int MUXN_NCH_DEF   = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first requester at or after start, wrapping modulo NCH
module rr_pick #(
  parameter  int NCH = 4,
  localparam int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  start,
  output logic           any,
  output logic [SW-1:0]  idx
);

  always_comb begin
    int          j;
    logic [SW-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    j    = 0;
    cand = '0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(start) + k;
      if (j >= NCH) j = j - NCH;
      cand = SW'(j);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - N-channel arbitrating mux with fixed/round-robin mode and registered output
module muxn_arb
  import muxn_pkg::*;
#(
  parameter  int WIDTH = MUXN_WIDTH_DEF,
  parameter  int NCH   = MUXN_NCH_DEF,
  localparam int SW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic             any;
  logic [SW-1:0]    g;
  logic [SW-1:0]    start_rr;
  logic [SW-1:0]    pick_start;

  // ptr sits at the last granted channel; round robin begins one past it
  assign start_rr   = (ptr_q == SW'(NCH - 1)) ? '0 : ptr_q + SW'(1);
  assign pick_start = (mode_e'(mode) == MODE_RR) ? start_rr : '0;
  assign load       = !out_valid_q || out_ready;

  rr_pick #(.NCH(NCH)) u_pick (
    .req   (in_valid),
    .start (pick_start),
    .any   (any),
    .idx   (g)
  );

  always_comb begin
    in_ready = '0;
    if (rst_n && load && any) in_ready[g] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = in_data[int'(g)*WIDTH +: WIDTH];
        out_sel_d  = g;
        ptr_d      = g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - randomized and directed checks of muxn_arb against a reference model
module tb_muxn_arb;
  import muxn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic        a_mode, a_ordy, a_ovalid;
  logic [7:0]  a_odata;
  logic [1:0]  a_osel;

  logic [23:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic        b_mode, b_ordy, b_ovalid;
  logic [7:0]  b_odata;
  logic [1:0]  b_osel;

  int checks = 0;
  int failures = 0;

  bit         m_valid[2];
  logic [7:0] m_data[2];
  int         m_sel[2], m_ptr[2], m_g[2];
  bit         m_load[2];

  muxn_arb #(.WIDTH(8), .NCH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_ordy)
  );

  muxn_arb #(.WIDTH(8), .NCH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_ordy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int n, input int ptr, input bit rr, input logic [3:0] vld);
    int s;
    s = rr ? (ptr + 1) % n : 0;
    for (int k = 0; k < n; k++)
      if (vld[(s + k) % n]) return (s + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 8'h00;
      m_sel[d]   = 0;
    end
    m_ptr[0] = 3;
    m_ptr[1] = 2;
  endtask

  task automatic pre(input int d, input int n, input logic [3:0] vld, input bit md,
                     input bit ordy, input logic [3:0] got);
    logic [3:0] er;
    er = 4'b0000;
    m_load[d] = !m_valid[d] || ordy;
    m_g[d]    = pick(n, m_ptr[d], md, vld);
    if (m_load[d] && m_g[d] >= 0) er[m_g[d]] = 1'b1;
    check(d == 0 ? "a_in_ready" : "b_in_ready", got, er);
  endtask

  task automatic post(input int d, input logic [31:0] data, input bit gv,
                      input logic [7:0] gd, input int gs);
    if (m_load[d]) begin
      if (m_g[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = data[8*m_g[d] +: 8];
        m_sel[d]   = m_g[d];
        m_ptr[d]   = m_g[d];
      end else begin
        m_valid[d] = 1'b0;
      end
    end
    check(d == 0 ? "a_out_valid" : "b_out_valid", gv, m_valid[d]);
    if (m_valid[d]) begin
      check(d == 0 ? "a_out_data" : "b_out_data", gd, m_data[d]);
      check(d == 0 ? "a_out_sel" : "b_out_sel", gs, m_sel[d]);
    end
  endtask

  task automatic cycle();
    #1;
    pre(0, 4, a_valid, a_mode, a_ordy, a_ready);
    pre(1, 3, {1'b0, b_valid}, b_mode, b_ordy, {1'b0, b_ready});
    @(posedge clk);
    #1;
    post(0, a_data, a_ovalid, a_odata, a_osel);
    post(1, {8'h00, b_data}, b_ovalid, b_odata, b_osel);
  endtask

  initial begin
    int exp_b[3];
    exp_b = '{0, 2, 0};
    rst_n = 1'b0;
    a_data = 32'h44332211; a_valid = 4'hF; a_mode = 1'b0; a_ordy = 1'b1;
    b_data = 24'hCCBBAA;   b_valid = 3'b111; b_mode = 1'b0; b_ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", a_ovalid, 1'b0);
    check("rst_out_data", a_odata, 8'h00);
    check("rst_out_sel", a_osel, 2'd0);
    check("rst_in_ready", a_ready, 4'h0);
    check("rst_b_in_ready", b_ready, 3'h0);
    check("rst_b_out_valid", b_ovalid, 1'b0);
    rst_n = 1'b1;
    model_reset();

    // round-robin sweep on NCH=4 while NCH=3 wraps from ptr=2
    a_mode = 1'b1; a_valid = 4'hF; b_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_valid = (k < 3) ? 3'b101 : 3'b000;
      cycle();
      check("rr_seq", a_osel, k % 4);
      if (k < 3) check("rr_wrap3", b_osel, exp_b[k]);
    end

    a_mode = 1'b0; a_valid = 4'b1010;
    repeat (3) begin
      cycle();
      check("fixed_sel", a_osel, 2'd1);
    end

    a_valid = 4'b0100; a_data = 32'h00A50000;
    cycle();
    a_ordy = 1'b0; a_valid = 4'hF; a_data = $urandom;
    repeat (5) begin
      cycle();
      check("bp_data", a_odata, 8'hA5);
      check("bp_sel", a_osel, 2'd2);
    end
    a_ordy = 1'b1;
    #1;
    check("bp_release", a_ready != 4'h0, 1'b1);
    cycle();

    a_mode = 1'b1; a_valid = 4'b0010;
    cycle();
    a_mode = 1'b0; a_valid = 4'b0111;
    cycle();
    check("mode_switch", a_osel, 2'd0);

    a_valid = 4'b0001; a_ordy = 1'b1;
    cycle();
    a_valid = 4'b0000; a_ordy = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", a_ovalid, 1'b0);
    check("rst_async_data", a_odata, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    a_mode = 1'b1; a_valid = 4'hF; a_ordy = 1'b1;
    cycle();
    check("rst_first_grant", a_osel, 2'd0);

    repeat (400) begin
      a_data  = $urandom;
      a_valid = 4'($urandom_range(15));
      a_mode  = 1'($urandom_range(1));
      a_ordy  = ($urandom_range(3) != 0);
      b_data  = 24'($urandom);
      b_valid = 3'($urandom_range(7));
      b_mode  = 1'($urandom_range(1));
      b_ordy  = ($urandom_range(3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
MUXN_ARB -- requirements
Module: muxn_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per channel in bits (range 1..64).
REQ-002 The block SHALL have parameter NCH, default 4, meaning the number of input channels (range 2..16).
REQ-003 The block SHALL have the localparam SW = $clog2(NCH), meaning the width of the channel index.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset, listed first: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_data  in  NCH*WIDTH  packed channel data, with channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  in  NCH  per-channel valid.
REQ-008 in_ready  out  NCH  per-channel ready, one-hot or all zero.
REQ-009 mode  in  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-010 out_data  out  WIDTH  registered selected data.
REQ-011 out_sel  out  SW  index of the channel that supplied out_data.
REQ-012 out_valid  out  1  out_data/out_sel hold a transfer.
REQ-013 out_ready  in  1  downstream accepts.

Function
REQ-014 The block SHALL define load = !out_valid | out_ready, and SHALL allow the output register to be written only when load=1.
REQ-015 When load=1 and in_valid!=0, the arbiter SHALL pick grant channel g, assert in_ready[g] only, and on the clock edge capture out_data<=in_data[g], out_sel<=g, out_valid<=1.
REQ-016 When load=0 or in_valid==0, in_ready SHALL be all zero.
REQ-017 When load=1 and in_valid==0, the block SHALL set out_valid<=0 at the edge.
REQ-018 Input-to-output latency SHALL be exactly 1 cycle, with sustained throughput of 1 transfer/cycle when out_ready is held at 1.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_sel SHALL hold stable and no input SHALL be accepted.
REQ-020 In mode 0, g SHALL be the lowest index i with in_valid[i]=1.
REQ-021 In mode 1, g SHALL be the first i with in_valid[i]=1, searching ptr+1, ptr+2, ... with modulo-NCH wrap (NCH-1 wraps to 0).
REQ-022 ptr SHALL update to g on every accepted input transfer, in both modes.
REQ-023 ptr SHALL be unchanged when no transfer occurs.
REQ-024 mode SHALL be sampled combinationally, and a mode change SHALL affect the arbitration decision in the same cycle.
REQ-025 With a single requester, that channel SHALL be granted every load cycle in either mode.
REQ-026 in_ready SHALL not depend combinationally on out_data, and the path from out_ready to in_ready SHALL be combinational (no skid buffer).
REQ-027 For non-power-of-two NCH, out_sel and ptr SHALL never take values >= NCH.

Reset
REQ-028 While rst_n=0, the block SHALL hold out_valid=0, out_data=0, out_sel=0, in_ready=0 and ptr=NCH-1, so that the first round-robin search starts at channel 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held output word immediately (asynchronously), without completing the handshake.
REQ-030 On the first clk edge after rst_n rises, the block SHALL accept input normally.

Structure
REQ-031 Package muxn_pkg SHALL hold the default constants MUXN_WIDTH_DEF=8 and MUXN_NCH_DEF=4 and the typedef mode_e {MODE_FIXED=0, MODE_RR=1}.
REQ-032 The block SHALL contain one combinational sub-module, rr_pick, parametrised by NCH, with inputs req[NCH], start[SW] and outputs any, idx[SW].
REQ-033 Mode 0 SHALL use rr_pick with start=0, and mode 1 SHALL use rr_pick with start=(ptr+1) mod NCH.
REQ-034 The block SHALL have no other state beyond the output register, out_sel and ptr.

Verification
REQ-035 Mode 1, NCH=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and one in_ready bit high per cycle.
REQ-036 Mode 0, in_valid=4'b1010 held for 3 cycles -> out_sel=1 on every cycle, with channel 3 starved.
REQ-037 Backpressure: load ch2 data 8'hA5, then out_ready=0 for 5 cycles -> out_data=8'hA5, out_sel=2 and in_ready=0 throughout; out_ready=1 -> next word is taken the same cycle.
REQ-038 NCH=3, mode 1, in_valid=3'b101 with ptr at 2 -> grant 0, then 2, then 0 (wrap-around with no out-of-range index).
REQ-039 Reset asserted while out_valid=1 and out_ready=0 -> out_valid falls immediately; after release, in_valid=4'b1111 in mode 1 -> first grant is channel 0.
REQ-040 Mode switch from 1 to 0 mid-stream with ptr=1 and in_valid=4'b0111 -> the grant in the same cycle is 0, not 2.
